// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits, internal baud divider.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the framer.
module uart_tx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          TxD
);

    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CNT_W = $clog2(DIV) + 1;

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY < 0 || PARITY > 2 || DIV < 2) begin : g_bad_params
        $error("uart_tx_param: illegal DATA_BITS/STOP_BITS/PARITY or baud divider below 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 txd_q;
    logic                 tick;
    logic                 word_avail;
    logic [DATA_BITS-1:0] word;
    logic                 load;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 push;

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    // Pointers carry one extra MSB so equal low bits mean empty or full depending on it.
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready   = ~full & rst;
    assign push       = tx_valid & tx_ready;
    assign word_avail = (wr_ptr != rd_ptr);
    assign word       = mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= tx_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
`else
    assign tx_ready   = (state == S_IDLE) & rst;
    assign word_avail = tx_valid & tx_ready;
    assign word       = tx_data;
    assign fifo_level = '0;
`endif

    assign load    = (state == S_IDLE) & word_avail;
    assign tick    = (state != S_IDLE) && (baud_cnt == CNT_W'(DIV - 1));
    assign tx_busy = (state != S_IDLE);
    assign TxD     = txd_q;

    // TxD is registered, so each transition loads the level of the bit that follows it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            baud_cnt <= (state == S_IDLE || tick) ? '0 : baud_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    txd_q   <= 1'b1;
                    if (load) begin
                        shift   <= word;
                        par_bit <= (PARITY == 2) ? ^word : ~^word;
                        state   <= S_START;
                        txd_q   <= 1'b0;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state <= S_DATA;
                        txd_q <= shift[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                txd_q <= par_bit;
                            end else begin
                                state <= S_STOP;
                                txd_q <= 1'b1;
                            end
                        end else begin
                            txd_q <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        txd_q <= 1'b1;
                    end
                end
                S_STOP: begin
                    txd_q <= 1'b1;
                    if (tick) begin
                        if (bit_cnt == 4'(STOP_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: six frame formats side by side, each checked cycle by cycle
// against a line-level model built from the word stream (FIFO timing when UART_TX_FIFO_EN is set).
module tb_uart_tx_param;

    localparam int NI    = 6;
    localparam int DEPTH = 4;
    localparam int DB  [NI] = '{8, 8, 8, 7, 9, 5};
    localparam int PAR [NI] = '{0, 2, 1, 0, 1, 2};
    localparam int SB  [NI] = '{1, 1, 1, 2, 2, 1};
    localparam int BR  [NI] = '{100000, 100000, 100000, 100000, 500000, 333333};
    localparam int DV  [NI] = '{10, 10, 10, 10, 2, 3};

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NI-1:0][8:0]   data;
    logic [NI-1:0]        valid;
    logic [NI-1:0]        ready;
    logic [NI-1:0]        busy;
    logic [NI-1:0]        txd;
    logic [NI-1:0][2:0]   level;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_param #(
            .CLK_FREQ  (1000000),
            .BAUD      (BR[g]),
            .DATA_BITS (DB[g]),
            .PARITY    (PAR[g]),
            .STOP_BITS (SB[g]),
            .FIFO_DEPTH(DEPTH)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .tx_data   (data[g][DB[g]-1:0]),
            .tx_valid  (valid[g]),
            .tx_ready  (ready[g]),
            .tx_busy   (busy[g]),
            .fifo_level(level[g]),
            .TxD       (txd[g])
        );
    end

    // Clock
    always #5 clk = ~clk;

    // Model state
    bit          exp_q     [NI][$];   // expected TxD level for each coming cycle of the frame(s)
    logic [8:0]  fifo_q    [NI][$];
    logic [8:0]  pend_q    [NI][$];
    logic        last_busy [NI];
    logic        acc       [NI];
    logic [8:0]  acc_word  [NI];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic add_frame(input int i, input logic [8:0] w);
        int v = int'(w) % (1 << DB[i]);
        int ones = 0;
        for (int k = 0; k < DV[i]; k++) exp_q[i].push_back(1'b0);
        for (int b = 0; b < DB[i]; b++) begin
            bit lvl = ((v >> b) % 2) == 1;
            ones += int'(lvl);
            for (int k = 0; k < DV[i]; k++) exp_q[i].push_back(lvl);
        end
        if (PAR[i] != 0) begin
            bit pb = (PAR[i] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            for (int k = 0; k < DV[i]; k++) exp_q[i].push_back(pb);
        end
        for (int k = 0; k < SB[i] * DV[i]; k++) exp_q[i].push_back(1'b1);
    endtask

    // Apply the clock edge that just happened to the model.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (!rst) begin
                exp_q[i].delete();
                fifo_q[i].delete();
                last_busy[i] = 1'b0;
            end else begin
`ifdef UART_TX_FIFO_EN
                if (!last_busy[i] && fifo_q[i].size() > 0) add_frame(i, fifo_q[i].pop_front());
                if (acc[i]) fifo_q[i].push_back(acc_word[i]);
`else
                if (acc[i]) add_frame(i, acc_word[i]);
`endif
            end
        end
    endtask

    function automatic logic ready_model(input int i, input logic r);
`ifdef UART_TX_FIFO_EN
        return r && (fifo_q[i].size() < DEPTH);
`else
        return r && !last_busy[i];
`endif
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            logic busy_e = exp_q[i].size() != 0;
            logic txd_e  = busy_e ? exp_q[i].pop_front() : 1'b1;
            last_busy[i] = busy_e;
            check($sformatf("u%0d_txd", i), 16'(txd[i]), 16'(txd_e));
            check($sformatf("u%0d_busy", i), 16'(busy[i]), 16'(busy_e));
            check($sformatf("u%0d_ready", i), 16'(ready[i]), 16'(ready_model(i, rst)));
            check($sformatf("u%0d_level", i), 16'(level[i]), 16'(fifo_q[i].size()));
        end
    endtask

    // Driver: offer the next pending word, optionally with random idle gaps.
    task automatic drive(input logic rst_next, input bit gaps);
        rst = rst_next;
        for (int i = 0; i < NI; i++) begin
            valid[i] = (pend_q[i].size() > 0) && (!gaps || $urandom_range(0, 1) == 1);
            data[i]  = valid[i] ? pend_q[i][0] : 9'($urandom);
            acc[i]   = valid[i] && ready_model(i, rst_next);
            acc_word[i] = data[i];
            if (acc[i]) void'(pend_q[i].pop_front());
        end
    endtask

    task automatic step(input logic rst_next, input bit gaps);
        @(negedge clk);
        model_edge();
        check_outputs();
        drive(rst_next, gaps);
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < NI; i++)
            n += pend_q[i].size() + exp_q[i].size() + fifo_q[i].size() + int'(last_busy[i]);
        return n;
    endfunction

    task automatic drain(input bit gaps, input int cap);
        int c = 0;
        while (outstanding() != 0 && c < cap) begin
            step(1'b1, gaps);
            c++;
        end
        check("drain_left", 16'(outstanding()), 16'd0);
    endtask

    task automatic push_all(input logic [8:0] w);
        for (int i = 0; i < NI; i++) pend_q[i].push_back(w);
    endtask

    initial begin
        rst   = 1'b0;
        valid = '0;
        data  = '0;
        for (int i = 0; i < NI; i++) begin
            acc[i]       = 1'b0;
            acc_word[i]  = '0;
            last_busy[i] = 1'b0;
        end

        // Reset held for a few cycles
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);

        // Directed words, then 16 incrementing words with valid held high
        push_all(9'h0A5);
        push_all(9'h001);
        push_all(9'h000);
        push_all(9'h041);
        push_all(9'h1FF);
        for (int k = 0; k < 16; k++) push_all(9'(8'h10 + k));
        drain(1'b0, 6000);

        // Reset in the middle of a frame, then a clean frame
        push_all(9'h0F0);
        push_all(9'h00F);
        for (int k = 0; k < 35; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < NI; i++) pend_q[i].delete();
        push_all(9'h03C);
        drain(1'b0, 1000);

        // Random words with random gaps in tx_valid
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 30; k++) pend_q[i].push_back(9'($urandom_range(0, 511)));
        drain(1'b1, 12000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
